// File: rtl/rgb_pwm_sequencer_pkg.sv
// Shared palette helper and parameter sanity checks for the RGB PWM sequencer.
package rgb_pkg;

  // Palette entry i lights the channels set in the binary value i+1.
  function automatic logic [15:0] palette_mask(input int unsigned idx, input int unsigned channels);
    logic [15:0] m;
    m = 16'(idx + 1);
    m = m & 16'((32'd1 << channels) - 1);
    return m;
  endfunction

  function automatic bit colours_ok(input int unsigned num_colours, input int unsigned channels);
    return (num_colours >= 2) && (num_colours <= (32'd1 << channels) - 1);
  endfunction

endpackage

// File: rtl/rgb_pwm_sequencer_debounce.sv
// Button front end: 2-FF synchroniser, debounce filter and rising-edge press pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          s1, s2, stable, armed;
  logic [1:0]    vld_pipe;
  logic [CW-1:0] cnt;
  logic          flip;

  // armed stays low until a real synced low is seen, so a button held through
  // reset never turns into a press.
  assign flip  = armed && (s2 != stable) && (cnt == CW'(DEBOUNCE_CYC - 1));
  assign press = flip & s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      vld_pipe <= '0;
      armed    <= 1'b0;
      stable   <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      vld_pipe <= {vld_pipe[0], 1'b1};
      if (vld_pipe[1] && !s2) armed <= 1'b1;
      if (!armed || (s2 == stable)) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// Palette sequencer: steps a colour index on press or auto tick, drives PWM-dimmed LEDs.
module rgb_pwm_sequencer
  import rgb_pkg::*;
#(
  parameter int CHANNELS     = 3,
  parameter int NUM_COLOURS  = 6,
  parameter int PWM_BITS     = 8,
  parameter int DEBOUNCE_CYC = 16,
  parameter int AUTO_PERIOD  = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           button,
  input  logic                           mode_auto,
  input  logic [PWM_BITS-1:0]            bright,
  output logic [CHANNELS-1:0]            rgb,
  output logic [$clog2(NUM_COLOURS)-1:0] colour_idx,
  output logic                           step
);
  localparam int IW = $clog2(NUM_COLOURS);
  localparam int PW = $clog2(AUTO_PERIOD);

  if (!colours_ok(NUM_COLOURS, CHANNELS)) begin : g_bad_colours
    $error("NUM_COLOURS out of range for CHANNELS");
  end
  if (AUTO_PERIOD < 2) begin : g_bad_period
    $error("AUTO_PERIOD must be >= 2");
  end

  logic                press, tick, advance;
  logic [PW-1:0]       presc;
  logic [PWM_BITS-1:0] pwm_cnt, bright_q;
  logic [CHANNELS-1:0] mask;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
    .clk   (clk),
    .rst   (rst),
    .raw   (button),
    .press (press)
  );

  assign tick    = mode_auto && (presc == PW'(AUTO_PERIOD - 1));
  assign advance = press | tick;
  assign mask    = CHANNELS'(palette_mask(32'(colour_idx), CHANNELS));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      colour_idx <= '0;
      step       <= 1'b0;
      pwm_cnt    <= '0;
      bright_q   <= '0;
      rgb        <= '0;
    end else begin
      presc <= (!mode_auto || tick) ? '0 : presc + 1'b1;
      step  <= advance;
      if (advance)
        colour_idx <= (colour_idx == IW'(NUM_COLOURS - 1)) ? '0 : colour_idx + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      // Brightness only changes at the period boundary so a duty update never glitches.
      if (&pwm_cnt) bright_q <= bright;
      rgb <= mask & {CHANNELS{pwm_cnt < bright_q}};
    end
  end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Randomised and directed bench for rgb_pwm_sequencer against a behavioural model.
module tb_rgb_pwm_sequencer;
  localparam int CH = 3, NC = 6, PB = 4, DC = 4, AP = 8;

  logic          clk = 1'b0, rst = 1'b1, button = 1'b0, mode_auto = 1'b0;
  logic [PB-1:0] bright = '0;
  logic [CH-1:0] rgb;
  logic [2:0]    colour_idx;
  logic          step;

  int checks = 0, errors = 0;

  // behavioural model state
  int m_q0, m_q1, m_edges, m_armed, m_stable, m_run, m_en_run;
  int m_idx, m_step, m_pwm, m_bq, m_rgb;

  rgb_pwm_sequencer #(
    .CHANNELS(CH), .NUM_COLOURS(NC), .PWM_BITS(PB),
    .DEBOUNCE_CYC(DC), .AUTO_PERIOD(AP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .mode_auto  (mode_auto),
    .bright     (bright),
    .rgb        (rgb),
    .colour_idx (colour_idx),
    .step       (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the specified behaviour, computed from the pre-edge state.
  task automatic model_edge();
    int s2, press, tick, nrgb;
    if (rst) begin
      m_q0 = 0; m_q1 = 0; m_edges = 0; m_armed = 0; m_stable = 0; m_run = 0;
      m_en_run = 0; m_idx = 0; m_step = 0; m_pwm = 0; m_bq = 0; m_rgb = 0;
      return;
    end
    s2 = m_q0; press = 0; tick = 0;
    nrgb = ((m_idx + 1) & ((1 << CH) - 1)) & ((m_pwm < m_bq) ? ((1 << CH) - 1) : 0);
    if (m_armed != 0) begin
      if (s2 == m_stable) m_run = 0;
      else begin
        m_run++;
        if (m_run == DC) begin m_stable = s2; m_run = 0; press = s2; end
      end
    end else m_run = 0;
    if (m_edges >= 2 && s2 == 0) m_armed = 1;
    if (m_edges < 2) m_edges++;
    m_q0 = m_q1; m_q1 = int'(button);
    if (mode_auto) begin
      tick = (m_en_run == AP - 1) ? 1 : 0;
      m_en_run = (m_en_run + 1) % AP;
    end else m_en_run = 0;
    m_step = press | tick;
    if (m_step != 0) m_idx = (m_idx + 1) % NC;
    if (m_pwm == (1 << PB) - 1) m_bq = int'(bright);
    m_pwm = (m_pwm + 1) % (1 << PB);
    m_rgb = nrgb;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("rgb", 32'(rgb), 32'(m_rgb));
    chk("idx", 32'(colour_idx), 32'(m_idx));
    chk("step", 32'(step), 32'(m_step));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int steps, ones, other, idx0;

  initial begin
    bright = 4'd15;
    run(3);
    chk("reset_rgb", 32'(rgb), 0);
    chk("reset_idx", 32'(colour_idx), 0);
    chk("reset_step", 32'(step), 0);
    rst = 1'b0;
    run(20);

    // clean press: step exactly on the 6th edge after the rise
    button = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      chk("t1_step", 32'(step), (k == 6) ? 1 : 0);
    end
    chk("t1_idx", 32'(colour_idx), 1);
    ones = 0; other = 0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      if (rgb == 3'b010) ones++; else if (rgb != 3'b000) other++;
    end
    chk("t1_mask_on", 32'(ones), 15);
    chk("t1_mask_other", 32'(other), 0);
    button = 1'b0; run(10);

    // 3-cycle glitch is filtered, 4-cycle pulse gives one step
    steps = 0; button = 1'b1;
    for (int k = 0; k < 3; k++) begin cycle(); steps += int'(step); end
    button = 1'b0;
    for (int k = 0; k < 10; k++) begin cycle(); steps += int'(step); end
    chk("t2_glitch_steps", 32'(steps), 0);
    chk("t2_glitch_idx", 32'(colour_idx), 1);
    steps = 0; button = 1'b1;
    for (int k = 0; k < 4; k++) begin cycle(); steps += int'(step); end
    button = 1'b0;
    for (int k = 0; k < 10; k++) begin cycle(); steps += int'(step); end
    chk("t2_pulse_steps", 32'(steps), 1);
    chk("t2_pulse_idx", 32'(colour_idx), 2);

    // auto advance: 6 steps in 48 cycles returns to the same index
    idx0 = int'(colour_idx); steps = 0; mode_auto = 1'b1;
    for (int k = 0; k < 48; k++) begin cycle(); steps += int'(step); end
    chk("t3_auto_steps", 32'(steps), 6);
    chk("t3_auto_wrap", 32'(colour_idx), 32'(idx0));
    mode_auto = 1'b0; run(3);

    // press swept across the tick phase, including exact coincidence
    for (int off = 0; off < 8; off++) begin
      idx0 = int'(colour_idx); steps = 0; mode_auto = 1'b1;
      for (int k = 0; k < off; k++) begin cycle(); steps += int'(step); end
      button = 1'b1;
      for (int k = off; k < 12; k++) begin cycle(); steps += int'(step); end
      mode_auto = 1'b0; button = 1'b0;
      for (int k = 0; k < 10; k++) begin cycle(); steps += int'(step); end
      chk("t4_steps", 32'(steps), (off == 2) ? 1 : 2);
      chk("t4_idx", 32'(colour_idx), 32'((idx0 + ((off == 2) ? 1 : 2)) % NC));
    end

    // duty: bright=4 on idx 0 is 4 of 16 on red only
    rst = 1'b1; run(1); rst = 1'b0;
    bright = 4'd4; run(40);
    ones = 0; other = 0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      if (rgb == 3'b001) ones++; else if (rgb != 3'b000) other++;
    end
    chk("t5_duty4", 32'(ones), 4);
    chk("t5_other", 32'(other), 0);
    run(5); bright = 4'd12; run(40);

    // reset mid-debounce with the button held: no press until re-pressed
    button = 1'b1; run(3);
    rst = 1'b1; run(1);
    chk("t6_rst_rgb", 32'(rgb), 0);
    chk("t6_rst_idx", 32'(colour_idx), 0);
    rst = 1'b0; steps = 0;
    for (int k = 0; k < 30; k++) begin cycle(); steps += int'(step); end
    chk("t6_held_steps", 32'(steps), 0);
    button = 1'b0; run(10);
    steps = 0; button = 1'b1;
    for (int k = 0; k < 10; k++) begin cycle(); steps += int'(step); end
    chk("t6_repress_steps", 32'(steps), 1);
    button = 1'b0; run(8);

    // random soak
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) button = ~button;
      if ($urandom_range(0, 60) == 0) mode_auto = ~mode_auto;
      if ($urandom_range(0, 20) == 0) bright = PB'($urandom);
      rst = ($urandom_range(0, 300) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
